// File: rtl/rom_pkg.sv
// Shared constants and the content function for the inverted-index ROM.
package rom_pkg;

  localparam int ROM_BIT_SIZE_DEFAULT  = 16;
  localparam int ROM_BIT_DEPTH_DEFAULT = 4;

  // Word i holds ~i; callers cast to the word width, which truncates or zero-extends.
  function automatic logic [63:0] rom_word(input int unsigned idx);
    return ~64'(idx);
  endfunction

endpackage

// File: rtl/rom_out_reg.sv
// Optional second output register for the ROM, present only when ROM_OUT_REG_EN is defined.
`ifdef ROM_OUT_REG_EN
module rom_out_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule
`endif

// File: rtl/rom.sv
// Synchronous-read ROM whose word i holds ~i; ROM_OUT_REG_EN adds a second output register stage.
module rom
  import rom_pkg::*;
#(
  parameter int BIT_SIZE  = ROM_BIT_SIZE_DEFAULT,
  parameter int BIT_DEPTH = ROM_BIT_DEPTH_DEFAULT,
  localparam int WORDS    = BIT_SIZE / BIT_DEPTH,
  localparam int AW       = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        addr,
  output logic [BIT_DEPTH-1:0] data_out
);

  if ((BIT_SIZE % BIT_DEPTH) != 0 || WORDS < 2) begin : g_param_check
    $error("rom: BIT_SIZE (%0d) must be a multiple of BIT_DEPTH (%0d) giving at least 2 words",
           BIT_SIZE, BIT_DEPTH);
  end

  logic [BIT_DEPTH-1:0] rom_table [WORDS];
  logic [BIT_DEPTH-1:0] rd_reg;

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_table
    assign rom_table[gi] = BIT_DEPTH'(rom_word(gi));
  end

  // Addresses past the last word exist only for non-power-of-two depths; they read as zero.
  always_ff @(posedge clk) begin
    if (rst)                    rd_reg <= '0;
    else if (int'(addr) < WORDS) rd_reg <= rom_table[addr];
    else                        rd_reg <= '0;
  end

`ifdef ROM_OUT_REG_EN
  rom_out_reg #(.WIDTH(BIT_DEPTH)) u_out_reg (
    .clk (clk),
    .rst (rst),
    .d   (rd_reg),
    .q   (data_out)
  );
`else
  assign data_out = rd_reg;
`endif

endmodule

// File: tb/tb_rom.sv
// Directed bench for rom: default, non-power-of-two and 8-bit-wide instances.
module tb_rom;

`ifdef ROM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] addr_a = '0;
  logic [1:0] addr_b = '0;
  logic [2:0] addr_c = '0;
  logic [3:0] data_a;
  logic [3:0] data_b;
  logic [7:0] data_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rom dut_a (.clk(clk), .rst(rst), .addr(addr_a), .data_out(data_a));
  rom #(.BIT_SIZE(12), .BIT_DEPTH(4)) dut_b (.clk(clk), .rst(rst), .addr(addr_b), .data_out(data_b));
  rom #(.BIT_SIZE(64), .BIT_DEPTH(8)) dut_c (.clk(clk), .rst(rst), .addr(addr_c), .data_out(data_c));

  task automatic test_reset();
    rst = 1'b1; addr_a = 2'd1; addr_b = 2'd1; addr_c = 3'd1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (data_a !== 4'h0) begin errors++; $display("FAIL reset_a: got %h want 0", data_a); end
    checks++; if (data_b !== 4'h0) begin errors++; $display("FAIL reset_b: got %h want 0", data_b); end
    checks++; if (data_c !== 8'h00) begin errors++; $display("FAIL reset_c: got %h want 00", data_c); end
    rst = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      @(posedge clk); #1;
      checks++;
      if (data_a !== ((k == LAT - 1) ? 4'hE : 4'h0)) begin
        errors++; $display("FAIL reset_release_%0d: got %h want %h", k, data_a, (k == LAT - 1) ? 4'hE : 4'h0);
      end
    end
    checks++; if (data_c !== 8'hFE) begin errors++; $display("FAIL reset_release_c: got %h want FE", data_c); end
    $display("test_reset done");
  endtask

  task automatic test_sweep();
    logic [1:0] a [8];
    logic [3:0] e [8];
    a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    e = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hF, 4'hE, 4'hD, 4'hC};
    for (int k = 0; k < 8 + LAT - 1; k++) begin
      if (k < 8) addr_a = a[k];
      @(posedge clk); #1;
      if (k >= LAT - 1) begin
        checks++;
        if (data_a !== e[k-LAT+1]) begin
          errors++; $display("FAIL sweep_%0d: got %h want %h", k - LAT + 1, data_a, e[k-LAT+1]);
        end else begin
          $display("sweep addr=%0d data=%h", a[k-LAT+1], data_a);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    addr_a = 2'd2;
    repeat (LAT) @(posedge clk);
    #1;
    checks++; if (data_a !== 4'hD) begin errors++; $display("FAIL mid_pre: got %h want D", data_a); end
    rst = 1'b1; addr_a = 2'd3;
    @(posedge clk); #1;
    checks++; if (data_a !== 4'h0) begin errors++; $display("FAIL mid_reset: got %h want 0", data_a); end
    rst = 1'b0; addr_a = 2'd0;
    repeat (LAT) @(posedge clk);
    #1;
    checks++; if (data_a !== 4'hF) begin errors++; $display("FAIL mid_resume: got %h want F", data_a); end
    $display("test_mid_reset done");
  endtask

  task automatic test_no_comb_path();
    addr_a = 2'd2;
    repeat (LAT) @(posedge clk);
    #1;
    addr_a = 2'd0;
    #3;
    checks++; if (data_a !== 4'hD) begin errors++; $display("FAIL no_comb: got %h want D", data_a); end
    $display("test_no_comb_path done");
  endtask

  task automatic test_non_pow2();
    logic [1:0] a [3];
    logic [3:0] e [3];
    a = '{2'd2, 2'd3, 2'd0};
    e = '{4'hD, 4'h0, 4'hF};
    for (int k = 0; k < 3; k++) begin
      addr_b = a[k];
      repeat (LAT) @(posedge clk);
      #1;
      checks++;
      if (data_b !== e[k]) begin
        errors++; $display("FAIL non_pow2_addr%0d: got %h want %h", a[k], data_b, e[k]);
      end else begin
        $display("non_pow2 addr=%0d data=%h", a[k], data_b);
      end
    end
  endtask

  task automatic test_width();
    logic [2:0] a [3];
    logic [7:0] e [3];
    a = '{3'd5, 3'd0, 3'd7};
    e = '{8'hFA, 8'hFF, 8'hF8};
    for (int k = 0; k < 3; k++) begin
      addr_c = a[k];
      repeat (LAT) @(posedge clk);
      #1;
      checks++;
      if (data_c !== e[k]) begin
        errors++; $display("FAIL width_addr%0d: got %h want %h", a[k], data_c, e[k]);
      end else begin
        $display("width addr=%0d data=%h", a[k], data_c);
      end
    end
  endtask

  task automatic test_latency();
    logic [3:0] s [3];
    addr_a = 2'd0;
    @(posedge clk); #1; s[0] = data_a;
    addr_a = 2'd3;
    @(posedge clk); #1; s[1] = data_a;
    @(posedge clk); #1; s[2] = data_a;
`ifdef ROM_OUT_REG_EN
    checks++; if (s[1] !== 4'hF) begin errors++; $display("FAIL latency_first: got %h want F", s[1]); end
    checks++; if (s[2] !== 4'hC) begin errors++; $display("FAIL latency_second: got %h want C", s[2]); end
`else
    checks++; if (s[0] !== 4'hF) begin errors++; $display("FAIL latency_first: got %h want F", s[0]); end
    checks++; if (s[1] !== 4'hC) begin errors++; $display("FAIL latency_second: got %h want C", s[1]); end
`endif
    $display("latency samples %h %h %h", s[0], s[1], s[2]);
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_mid_reset();
    test_no_comb_path();
    test_non_pow2();
    test_width();
    test_latency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rom.md
ROM -- requirements
Module: rom

Interface
REQ-001 The block SHALL have parameter BIT_SIZE, default 16, meaning total ROM capacity in bits.
REQ-002 The block SHALL have parameter BIT_DEPTH, default 4, meaning data word width in bits.
REQ-003 The block SHALL define localparam WORDS = BIT_SIZE/BIT_DEPTH, the number of stored words, with AW = $clog2(WORDS).
REQ-004 The block SHALL have port clk, input, width 1, the single rising-edge clock.
REQ-005 The block SHALL have port rst, input, width 1, a synchronous active-high reset.
REQ-006 The block SHALL have port addr, input, width AW, the word address.
REQ-007 The block SHALL have port data_out, output, width BIT_DEPTH, the registered read data.

Function
REQ-008 The block SHALL hold WORDS read-only words; word i SHALL contain the bitwise inversion of i, truncated or zero-extended to BIT_DEPTH bits (defaults: 0->F, 1->E, 2->D, 3->C).
REQ-009 A read SHALL be synchronous: addr sampled at rising edge N SHALL appear on data_out after edge N and hold until edge N+1 (latency 1 cycle; no enable; a read every cycle).
REQ-010 data_out SHALL change only on a rising clk edge and never combinationally with addr.
REQ-011 An addr value >= WORDS (possible only when WORDS is not a power of two) SHALL read as all-zero data.
REQ-012 Repeated or back-to-back reads of any address sequence SHALL return identical data every pass; contents SHALL never change at runtime.
REQ-013 Elaboration SHALL fail (via $error or equivalent) if BIT_SIZE is not an exact multiple of BIT_DEPTH, or if WORDS < 2.

Reset
REQ-014 While rst is high at a rising edge, data_out SHALL be set to 0 regardless of addr.
REQ-015 On the first rising edge with rst low, the block SHALL perform a normal read of addr; no extra recovery cycles.
REQ-016 If rst is asserted mid-sequence, data_out SHALL be 0 from the next edge onward, and normal reads SHALL resume as in REQ-015; ROM contents are unaffected.

Configuration
REQ-017 When macro ROM_OUT_REG_EN is defined, the block SHALL add a second output register stage: read latency becomes 2 cycles, and both stages SHALL reset to 0 under rst.
REQ-018 When ROM_OUT_REG_EN is not defined, latency SHALL be exactly 1 cycle as in REQ-009, and no second stage SHALL exist.

Structure
REQ-019 A shared package rom_pkg SHALL hold the content function (word index -> inverted value) and the default BIT_SIZE/BIT_DEPTH constants.
REQ-020 The optional output stage SHALL be a sub-module rom_out_reg (parameter WIDTH; ports clk, rst, d, q), instantiated only under ROM_OUT_REG_EN.

Verification
REQ-021 The bench SHALL check the default sweep: after reset, drive addr=0,1,2,3 for one cycle each; data_out SHALL read F, E, D, C one cycle after each address.
REQ-022 The bench SHALL check a second identical sweep 0..3 immediately after the first; it SHALL again read F, E, D, C with no gap cycles.
REQ-023 The bench SHALL check reset dominance: hold addr=1 with rst=1 for 2 edges; data_out SHALL be 0; after rst falls, the next edge SHALL give E.
REQ-024 The bench SHALL check non-power-of-two depth: BIT_SIZE=12, BIT_DEPTH=4 (WORDS=3, AW=2); addr=2 SHALL give D and addr=3 SHALL give 0.
REQ-025 The bench SHALL check latency with ROM_OUT_REG_EN defined: addr=0 then 3 on consecutive edges; F SHALL appear two edges after addr=0 and C one edge after that.
REQ-026 The bench SHALL check width scaling: BIT_SIZE=64, BIT_DEPTH=8 (WORDS=8); addr=5 SHALL give 8'hFA.
